// File: rtl/cache_refill_controller_pkg.sv
// CacheSystemTypes: shared cache-system widths and refill-controller types.
//   WAY_NUM          ways per set (also the LRU counter's width source)
//   INDEX_BIT_WIDTH  set index width
//   TAG_BIT_WIDTH    tag width
//   LINE_BIT_WIDTH   cache line width
//   RefillState      miss-handling FSM states
//   MemFillReq       {tag, index} line-fill address as sent to memory
package CacheSystemTypes;
    localparam int WAY_NUM         = 2;
    localparam int INDEX_BIT_WIDTH = 9;
    localparam int TAG_BIT_WIDTH   = 20;
    localparam int LINE_BIT_WIDTH  = 128;

    typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, FILL} RefillState;

    // Tag in the upper bits so the packed struct is directly {tag, index}.
    typedef struct packed {
        logic [TAG_BIT_WIDTH-1:0]   tag;
        logic [INDEX_BIT_WIDTH-1:0] index;
    } MemFillReq;
endpackage

// File: rtl/cache_refill_controller.sv
// cache_refill_controller: single-outstanding-miss refill engine.
// Accepts a miss, asks the LRU counter for the victim way of the missed set,
// issues one line-fill request, waits for the data, then writes the line into
// the victim way and reports that way back to the LRU counter as an access.
// Ports:
//   clk, rst                      clock / async active-low reset
//   missValid/Index/Tag, missReady    miss request handshake
//   lruIndex, lruWay              victim lookup on the LRU counter
//   memReqValid/Addr/Ready        line-fill request to memory
//   memRspValid/Data              fill response from memory
//   fillValid/Index/Way/Tag/Data  data/tag array write
//   lruAccess, lruAccessWay       LRU update for the filled way
//   protocolError                 sticky: response arrived outside WAIT
// Tag/index widths must match CacheSystemTypes, since MemFillReq is sized there.
module cache_refill_controller
    import CacheSystemTypes::*;
#(
    parameter int WAY_NUM         = CacheSystemTypes::WAY_NUM,
    parameter int INDEX_BIT_WIDTH = CacheSystemTypes::INDEX_BIT_WIDTH,
    parameter int TAG_BIT_WIDTH   = CacheSystemTypes::TAG_BIT_WIDTH,
    parameter int LINE_BIT_WIDTH  = CacheSystemTypes::LINE_BIT_WIDTH,
    localparam int WAY_BIT_WIDTH  = $clog2(WAY_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   missValid,
    input  logic [INDEX_BIT_WIDTH-1:0]             missIndex,
    input  logic [TAG_BIT_WIDTH-1:0]               missTag,
    output logic                                   missReady,
    output logic [INDEX_BIT_WIDTH-1:0]             lruIndex,
    input  logic [WAY_BIT_WIDTH-1:0]               lruWay,
    output logic                                   memReqValid,
    output logic [TAG_BIT_WIDTH+INDEX_BIT_WIDTH-1:0] memReqAddr,
    input  logic                                   memReqReady,
    input  logic                                   memRspValid,
    input  logic [LINE_BIT_WIDTH-1:0]              memRspData,
    output logic                                   fillValid,
    output logic [INDEX_BIT_WIDTH-1:0]             fillIndex,
    output logic [WAY_BIT_WIDTH-1:0]               fillWay,
    output logic [TAG_BIT_WIDTH-1:0]               fillTag,
    output logic [LINE_BIT_WIDTH-1:0]              fillData,
    output logic                                   lruAccess,
    output logic [WAY_BIT_WIDTH-1:0]               lruAccessWay,
    output logic                                   protocolError
);
    RefillState                state, next_state;
    MemFillReq                 req_q;
    logic [WAY_BIT_WIDTH-1:0]  victim_q;
    logic [LINE_BIT_WIDTH-1:0] data_q;
    logic                      perr_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (missValid)   next_state = LOOKUP;
            LOOKUP:                   next_state = REQ;
            REQ:     if (memReqReady) next_state = WAIT;
            WAIT:    if (memRspValid) next_state = FILL;
            FILL:                     next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Datapath registers. The victim is captured only in LOOKUP so later LRU
    // movement on the same set cannot redirect the fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= '0;
            victim_q <= '0;
            data_q   <= '0;
            perr_q   <= 1'b0;
        end else begin
            if (state == IDLE && missValid)
                req_q <= '{tag: missTag, index: missIndex};
            if (state == LOOKUP)
                victim_q <= lruWay;
            if (state == WAIT && memRspValid)
                data_q <= memRspData;
            // Any response not awaited (including one coinciding with the
            // request handshake) is dropped and flagged.
            if (memRspValid && state != WAIT)
                perr_q <= 1'b1;
        end
    end

    // Outputs: register contents gated by state only, so no input reaches an
    // output combinationally.
    always_comb begin
        missReady     = (state == IDLE);
        memReqValid   = (state == REQ);
        memReqAddr    = '0;
        fillValid     = (state == FILL);
        fillIndex     = '0;
        fillWay       = '0;
        fillTag       = '0;
        fillData      = '0;
        lruAccess     = (state == FILL);
        lruAccessWay  = '0;
        // Last latched index doubles as the lookup (LOOKUP) and update (FILL)
        // index and stays deterministic elsewhere.
        lruIndex      = req_q.index;
        protocolError = perr_q;
        if (state == REQ)
            memReqAddr = req_q;
        if (state == FILL) begin
            fillIndex    = req_q.index;
            fillWay      = victim_q;
            fillTag      = req_q.tag;
            fillData     = data_q;
            lruAccessWay = victim_q;
        end
    end
endmodule

// File: tb/tb_cache_refill_controller.sv
// Bench for cache_refill_controller: transaction-level model + per-cycle
// compare, plus literal expectations from directed scenarios.
module tb_cache_refill_controller;
    import CacheSystemTypes::*;
    localparam int WB = $clog2(WAY_NUM);
    localparam int AW = TAG_BIT_WIDTH + INDEX_BIT_WIDTH;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       missValid = 1'b0;
    logic [INDEX_BIT_WIDTH-1:0] missIndex = '0;
    logic [TAG_BIT_WIDTH-1:0]   missTag = '0;
    logic                       missReady;
    logic [INDEX_BIT_WIDTH-1:0] lruIndex;
    logic [WB-1:0]              lruWay = '0;
    logic                       memReqValid;
    logic [AW-1:0]              memReqAddr;
    logic                       memReqReady = 1'b0;
    logic                       memRspValid = 1'b0;
    logic [LINE_BIT_WIDTH-1:0]  memRspData = '0;
    logic                       fillValid;
    logic [INDEX_BIT_WIDTH-1:0] fillIndex;
    logic [WB-1:0]              fillWay;
    logic [TAG_BIT_WIDTH-1:0]   fillTag;
    logic [LINE_BIT_WIDTH-1:0]  fillData;
    logic                       lruAccess;
    logic [WB-1:0]              lruAccessWay;
    logic                       protocolError;

    cache_refill_controller dut (
        .clk(clk), .rst(rst),
        .missValid(missValid), .missIndex(missIndex), .missTag(missTag), .missReady(missReady),
        .lruIndex(lruIndex), .lruWay(lruWay),
        .memReqValid(memReqValid), .memReqAddr(memReqAddr), .memReqReady(memReqReady),
        .memRspValid(memRspValid), .memRspData(memRspData),
        .fillValid(fillValid), .fillIndex(fillIndex), .fillWay(fillWay), .fillTag(fillTag),
        .fillData(fillData), .lruAccess(lruAccess), .lruAccessWay(lruAccessWay),
        .protocolError(protocolError)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: one outstanding miss tracked by milestones reached
    // (victim known, request accepted, data returned).
    bit                         m_busy = 0, m_vic_ok = 0, m_req_done = 0, m_rsp_done = 0, m_perr = 0;
    logic [INDEX_BIT_WIDTH-1:0] m_idx = '0;
    logic [TAG_BIT_WIDTH-1:0]   m_tag = '0;
    logic [WB-1:0]              m_vic = '0;
    logic [LINE_BIT_WIDTH-1:0]  m_data = '0;
    int                         acc_edge = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_vic_ok = 0; m_req_done = 0; m_rsp_done = 0; m_perr = 0;
            m_idx = '0;
        end else begin
            bit awaiting;
            awaiting = m_busy && m_req_done && !m_rsp_done;
            if (memRspValid && !awaiting) m_perr = 1;
            if (m_rsp_done) begin
                m_busy = 0; m_vic_ok = 0; m_req_done = 0; m_rsp_done = 0;
            end else if (m_busy) begin
                if (!m_vic_ok) begin
                    m_vic = lruWay; m_vic_ok = 1;
                end else if (!m_req_done) begin
                    if (memReqReady) m_req_done = 1;
                end else if (memRspValid) begin
                    m_data = memRspData; m_rsp_done = 1;
                end
            end else if (missValid) begin
                m_busy = 1; m_idx = missIndex; m_tag = missTag; acc_edge = cyc + 1;
            end
        end
    end

    // Captures for directed checks
    int                        fill_cnt = 0, lacc_cnt = 0, fill_cyc = 0;
    logic [WB-1:0]             cap_way = '0, cap_law = '0;
    logic [LINE_BIT_WIDTH-1:0] cap_data = '0;
    logic [AW-1:0]             cap_addr = '0;

    always @(negedge clk) begin
        if (chk_on) begin
            bit e_req;
            e_req = m_busy && m_vic_ok && !m_req_done;
            chk("missReady", 128'(missReady), 128'(!m_busy));
            chk("memReqValid", 128'(memReqValid), 128'(e_req));
            if (e_req) chk("memReqAddr", 128'(memReqAddr), 128'({m_tag, m_idx}));
            chk("fillValid", 128'(fillValid), 128'(m_rsp_done));
            chk("lruAccess", 128'(lruAccess), 128'(m_rsp_done));
            if (m_rsp_done) begin
                chk("fillIndex", 128'(fillIndex), 128'(m_idx));
                chk("fillTag", 128'(fillTag), 128'(m_tag));
                chk("fillWay", 128'(fillWay), 128'(m_vic));
                chk("fillData", fillData, m_data);
                chk("lruAccessWay", 128'(lruAccessWay), 128'(m_vic));
            end
            chk("lruIndex", 128'(lruIndex), 128'(m_idx));
            chk("protocolError", 128'(protocolError), 128'(m_perr));
        end
        if (fillValid === 1'b1) begin
            fill_cnt++; fill_cyc = cyc; cap_way = fillWay; cap_data = fillData;
        end
        if (lruAccess === 1'b1) begin
            lacc_cnt++; cap_law = lruAccessWay;
        end
        if (memReqValid === 1'b1) cap_addr = memReqAddr;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".missReady"}, 128'(missReady), 128'(1));
        chk({tag, ".memReqValid"}, 128'(memReqValid), 128'(0));
        chk({tag, ".memReqAddr"}, 128'(memReqAddr), 128'(0));
        chk({tag, ".fillValid"}, 128'(fillValid), 128'(0));
        chk({tag, ".fillIndex"}, 128'(fillIndex), 128'(0));
        chk({tag, ".fillWay"}, 128'(fillWay), 128'(0));
        chk({tag, ".fillTag"}, 128'(fillTag), 128'(0));
        chk({tag, ".fillData"}, fillData, 128'(0));
        chk({tag, ".lruAccess"}, 128'(lruAccess), 128'(0));
        chk({tag, ".lruAccessWay"}, 128'(lruAccessWay), 128'(0));
        chk({tag, ".lruIndex"}, 128'(lruIndex), 128'(0));
        chk({tag, ".protocolError"}, 128'(protocolError), 128'(0));
    endtask

    // One miss. Handshake at edge T+2+req_stall, response rsp_delay cycles
    // after the earliest legal one; lruWay switches to way1 after sampling.
    task automatic run_miss(input string name, input logic [INDEX_BIT_WIDTH-1:0] idx,
                            input logic [TAG_BIT_WIDTH-1:0] tag, input logic [LINE_BIT_WIDTH-1:0] data,
                            input logic [WB-1:0] way0, input logic [WB-1:0] way1,
                            input int req_stall, input int rsp_delay,
                            input int exp_lat, input logic [WB-1:0] exp_way, input logic [AW-1:0] exp_addr);
        int hs, rs, nf, nl;
        hs = 2 + req_stall;
        rs = hs + 1 + rsp_delay;
        nf = fill_cnt; nl = lacc_cnt;
        @(posedge clk); #1;
        missValid = 1; missIndex = idx; missTag = tag; lruWay = way0;
        memReqReady = 0; memRspValid = 0;
        @(posedge clk); #1;
        missValid = 0;
        for (int k = 0; k < rs + 3; k++) begin
            memReqReady = (k + 1 == hs);
            memRspValid = (k + 1 == rs);
            memRspData  = data;
            lruWay      = (k >= 1) ? way1 : way0;
            @(posedge clk); #1;
        end
        memReqReady = 0; memRspValid = 0;
        chk({name, ".fills"}, 128'(fill_cnt - nf), 128'(1));
        chk({name, ".lruPulses"}, 128'(lacc_cnt - nl), 128'(1));
        chk({name, ".latency"}, 128'(fill_cyc + 1 - acc_edge), 128'(exp_lat));
        chk({name, ".fillWay"}, 128'(cap_way), 128'(exp_way));
        chk({name, ".lruAccessWay"}, 128'(cap_law), 128'(exp_way));
        chk({name, ".fillData"}, cap_data, data);
        chk({name, ".memReqAddr"}, 128'(cap_addr), 128'(exp_addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, nl;
        // Reset then idle
        #2 rst = 0;
        #1 chk_on = 1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("inReset");
        rst = 1;
        @(posedge clk); #1 check_reset_outputs("afterReset");
        repeat (20) @(posedge clk);
        #1 chk("idleNoFill", 128'(fill_cnt), 128'(0));

        // Basic miss
        run_miss("basic", 9'h005, 20'h12345, {16{8'hA5}}, 1'b1, 1'b1, 0, 0,
                 4, 1'b1, 29'h2468A05);

        // Stalls: 3 cycles without ready, response 4 cycles late
        run_miss("stall", 9'h0AA, 20'h54321, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                 1'b0, 1'b0, 3, 4, 11, 1'b0, 29'(32'h54321 * 512 + 32'h0AA));

        // Victim freeze: LRU moves to way 1 after way 0 was sampled
        run_miss("freeze", 9'h1F0, 20'h0BEEF, {4{32'hDEAD_BEEF}}, 1'b0, 1'b1, 0, 2,
                 6, 1'b0, 29'(32'h0BEEF * 512 + 32'h1F0));

        // Unexpected response in IDLE
        nf = fill_cnt;
        @(posedge clk); #1 memRspValid = 1; memRspData = '1;
        @(posedge clk); #1 memRspValid = 0;
        chk("unexp.perr", 128'(protocolError), 128'(1));
        repeat (5) @(posedge clk);
        #1 chk("unexp.sticky", 128'(protocolError), 128'(1));
        chk("unexp.noFill", 128'(fill_cnt - nf), 128'(0));
        run_miss("afterErr", 9'h1FF, 20'hFFFFF, {8{16'h5A3C}}, 1'b1, 1'b0, 0, 0,
                 4, 1'b1, 29'h1FFFFFFF);

        // Reset in the middle of WAIT, then a late response
        nf = fill_cnt; nl = lacc_cnt;
        @(posedge clk); #1 missValid = 1; missIndex = 9'h033; missTag = 20'hABCDE; lruWay = 1'b1;
        @(posedge clk); #1 missValid = 0; memReqReady = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 memReqReady = 0;
        @(posedge clk); #1 rst = 0;
        #2 chk("rstWait.missReady", 128'(missReady), 128'(1));
        chk("rstWait.perrCleared", 128'(protocolError), 128'(0));
        @(posedge clk); @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 memRspValid = 1; memRspData = {16{8'h77}};
        @(posedge clk); #1 memRspValid = 0;
        repeat (5) @(posedge clk);
        #1 chk("rstWait.noFill", 128'(fill_cnt - nf), 128'(0));
        chk("rstWait.noLru", 128'(lacc_cnt - nl), 128'(0));
        chk("rstWait.idle", 128'(missReady), 128'(1));
        chk("rstWait.perr", 128'(protocolError), 128'(1));

        repeat (2) @(posedge clk);
        #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
